// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command sequencer in front of the AND/ADD ALU
//
// Accepts one command per in_valid/in_ready handshake, drives registered
// operands onto the ALU, captures result/flags after a one-cycle settle, and
// presents them on an out_valid/out_ready handshake.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready                 command handshake
//   in_a, in_b, in_op, in_acc         operands, op (0=AND 1=ADD), accumulate select
//   alu_a, alu_b, alu_op              registered ALU inputs
//   alu_res, alu_gz, alu_cf           ALU combinational result and flags
//   out_valid/out_ready               result handshake
//   out_res, out_gz, out_cf           captured result and flags
//   op_count                          saturating completed-operation counter
module alu_seq_ctrl #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_gz,
    input  logic             alu_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_gz,
    output logic             out_cf,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_reg;

    // Handshake outputs depend on state only, so they never combinationally
    // follow in_valid/out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = EXEC;
            EXEC:                   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ALU operand registers: loaded only on an accepted command so the ALU
    // inputs stay stable for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            alu_a  <= in_acc ? acc_reg : in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
        end
    end

    // Result capture at the end of the settle cycle; acc_reg only moves on
    // completed operations, so a reset-aborted op leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res  <= '0;
            out_gz   <= 1'b0;
            out_cf   <= 1'b0;
            acc_reg  <= '0;
            op_count <= '0;
        end else if (state_q == EXEC) begin
            out_res <= alu_res;
            out_gz  <= alu_gz;
            out_cf  <= alu_cf;
            acc_reg <= alu_res;
            if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready, in_ready2;
    logic [W-1:0] in_a, in_b;
    logic         in_op, in_acc;
    logic [W-1:0] alu_a, alu_b, alu_a2, alu_b2;
    logic         alu_op, alu_op2;
    logic [W-1:0] alu_res, alu_res2;
    logic         alu_gz, alu_cf, alu_gz2, alu_cf2;
    logic         out_valid, out_valid2;
    logic         out_ready;
    logic [W-1:0] out_res, out_res2;
    logic         out_gz, out_cf, out_gz2, out_cf2;
    logic [7:0]   op_count;
    logic [1:0]   op_count2;

    int errors = 0;
    int checks = 0;

    logic [W+1:0] sb[$];
    logic [W-1:0] acc_m;
    int           cnt_m;

    always #5 clk = ~clk;

    // Behavioural ALU driving each DUT's ALU inputs.
    logic [W:0] sum1, sum2;
    assign sum1     = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_res  = alu_op ? sum1[W-1:0] : (alu_a & alu_b);
    assign alu_gz   = (alu_res != '0);
    assign alu_cf   = alu_op ? sum1[W] : 1'b0;
    assign sum2     = {1'b0, alu_a2} + {1'b0, alu_b2};
    assign alu_res2 = alu_op2 ? sum2[W-1:0] : (alu_a2 & alu_b2);
    assign alu_gz2  = (alu_res2 != '0);
    assign alu_cf2  = alu_op2 ? sum2[W] : 1'b0;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_gz(alu_gz), .alu_cf(alu_cf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_gz(out_gz), .out_cf(out_cf),
        .op_count(op_count)
    );

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2),
        .alu_res(alu_res2), .alu_gz(alu_gz2), .alu_cf(alu_cf2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_res(out_res2), .out_gz(out_gz2), .out_cf(out_cf2),
        .op_count(op_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
        logic [W:0]   s;
        logic [W-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = op ? s[W-1:0] : (a & b);
        return {op & s[W], (r != '0), r};
    endfunction

    // Issues one command from a negedge in IDLE; holds DONE for 'hold' cycles
    // with in_valid pulsing, then releases. Ends on a negedge back in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic acc, input int hold);
        logic [W-1:0] a_eff;
        logic [W+1:0] e;
        chk("in_ready_idle", 32'(in_ready), 1);
        a_eff = acc ? acc_m : a;
        sb.push_back(model(a_eff, b, op));
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_acc    = acc;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        chk("exec_out_valid", 32'(out_valid), 0);
        chk("exec_in_ready", 32'(in_ready), 0);
        chk("alu_a", 32'(alu_a), 32'(a_eff));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("alu_op", 32'(alu_op), 32'(op));
        @(posedge clk);
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("out_res", 32'(out_res), 32'(e[W-1:0]));
        chk("out_gz", 32'(out_gz), 32'(e[W]));
        chk("out_cf", 32'(out_cf), 32'(e[W+1]));
        acc_m = e[W-1:0];
        if (cnt_m < 255) cnt_m++;
        chk("op_count", 32'(op_count), 32'(cnt_m));
        chk("op_count_cnt2", 32'(op_count2), 32'((cnt_m > 3) ? 3 : cnt_m));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = 7'h2A;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_res", 32'(out_res), 32'(e[W-1:0]));
            chk("bp_alu_a", 32'(alu_a), 32'(a_eff));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ret_out_valid", 32'(out_valid), 0);
        chk("ret_in_ready", 32'(in_ready), 1);
        chk("ret_op_count", 32'(op_count), 32'(cnt_m));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        in_acc    = 1'b0;
        out_ready = 1'b0;
        acc_m     = '0;
        cnt_m     = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_out_res", 32'(out_res), 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Accumulate right after reset uses acc_reg = 0: 0 + 3.
        do_op(7'h11, 7'h03, 1'b1, 1'b1, 0);
        do_op(7'h55, 7'h0F, 1'b0, 1'b0, 0);
        do_op(7'h7F, 7'h01, 1'b1, 1'b0, 0);
        do_op(7'h10, 7'h05, 1'b1, 1'b0, 0);
        do_op(7'h00, 7'h03, 1'b1, 1'b1, 0);
        chk("chain_result", 32'(out_res), 32'h18);
        do_op(7'h33, 7'h3C, 1'b0, 1'b0, 5);

        // Reset while in EXEC: op discarded.
        in_valid = 1'b1;
        in_a     = 7'h44;
        in_b     = 7'h01;
        in_op    = 1'b1;
        in_acc   = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstx_out_valid", 32'(out_valid), 0);
        chk("rstx_in_ready", 32'(in_ready), 1);
        chk("rstx_op_count", 32'(op_count), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        acc_m    = '0;
        cnt_m    = 0;
        @(negedge clk);
        chk("rstx_rel_in_ready", 32'(in_ready), 1);
        chk("rstx_rel_out_valid", 32'(out_valid), 0);

        // Reset while in DONE: out_valid drops without a clock edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rstd_pre_out_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rstd_out_valid", 32'(out_valid), 0);
        chk("rstd_op_count", 32'(op_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Accumulate after reset again starts from 0.
        do_op(7'h7F, 7'h06, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) do_op(7'(i * 9 + 1), 7'h02, 1'b1, 1'b0, 0);
        chk("cnt2_sat", 32'(op_count2), 3);

        // Random traffic, enough to push the 8-bit counter into saturation.
        for (int i = 0; i < 255; i++) begin
            do_op(7'($urandom), 7'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 0);
        end
        chk("cnt8_sat", 32'(op_count), 255);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
